spike_tick_scheduler: RTL

SPIKE_TICK_SCHEDULER -- requirements
Module: spike_tick_scheduler

---
 rtl/spike_tick_scheduler.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/spike_tick_scheduler.sv
// spike_tick_scheduler: steps a spike core through a run of timesteps.
// Each step pulses start_o with the current tick, then waits for the
// neuron update to start and finish and for the spike output path to
// drain. Tick counts down one per step. A timeout fires if the neuron
// update never starts, and abort_i stops the run at any point.
// Ports:
//   CLK, RST             clock, async active-high reset
//   run_i, abort_i       run request / abort request (one cycle each)
//   cfg_tick_start_i     first tick value, sampled when a run is accepted
//   cfg_num_steps_i      number of steps, sampled when a run is accepted
//   LIF_busy_i           neuron update in progress
//   LIF_done_i           neuron update finished
//   out_idle_i           spike output path drained
//   start_o              one-cycle step launch pulse (registered)
//   tick_o               tick value for the current step
//   control_o            high while a step is in flight
//   busy_o               high whenever the scheduler is not idle
//   done_o               one-cycle run completion pulse (registered)
//   error_o              sticky timeout flag (registered)
//   steps_left_o         remaining steps, including the current one
module spike_tick_scheduler #(
    parameter int INPUT_RESO = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  run_i,
    input  logic                  abort_i,
    input  logic [INPUT_RESO-1:0] cfg_tick_start_i,
    input  logic [INPUT_RESO-1:0] cfg_num_steps_i,
    input  logic                  LIF_busy_i,
    input  logic                  LIF_done_i,
    input  logic                  out_idle_i,
    output logic                  start_o,
    output logic [INPUT_RESO-1:0] tick_o,
    output logic                  control_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [INPUT_RESO-1:0] steps_left_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_DRAIN     = 3'd4,
        S_ADVANCE   = 3'd5,
        S_FINISH    = 3'd6
    } state_t;

    state_t                  state_q, state_d;
    logic [INPUT_RESO-1:0]   tick_q, tick_d;
    logic [INPUT_RESO-1:0]   steps_q, steps_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic                    error_q, error_d;
    logic                    start_q, start_d;
    logic                    done_q, done_d;
    logic                    control_q, control_d;
    logic                    busy_q, busy_d;
    logic                    tmo_hit;
    logic                    last_step;

    // The counter is cleared in ISSUE and steps once per WAIT_BUSY
    // cycle; firing when the increment would land on TIMEOUT-1 puts
    // error_o high exactly TIMEOUT cycles after the start_o pulse.
    assign tmo_hit   = (tmo_q == TW'(TIMEOUT - 2));
    assign last_step = (steps_q == INPUT_RESO'(1));

    // State and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            tick_q    <= '0;
            steps_q   <= '0;
            tmo_q     <= '0;
            error_q   <= 1'b0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            control_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            steps_q   <= steps_d;
            tmo_q     <= tmo_d;
            error_q   <= error_d;
            start_q   <= start_d;
            done_q    <= done_d;
            control_q <= control_d;
            busy_q    <= busy_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (run_i) begin
                        if (cfg_num_steps_i != '0) state_d = S_ISSUE;
                        else                       state_d = S_FINISH;
                    end
                end
                S_ISSUE:     state_d = S_WAIT_BUSY;
                S_WAIT_BUSY: begin
                    if (LIF_busy_i)   state_d = S_WAIT_DONE;
                    else if (tmo_hit) state_d = S_IDLE;
                end
                S_WAIT_DONE: begin
                    if (LIF_done_i && !LIF_busy_i) state_d = S_DRAIN;
                end
                S_DRAIN: begin
                    if (out_idle_i) state_d = S_ADVANCE;
                end
                S_ADVANCE: begin
                    if (last_step) state_d = S_FINISH;
                    else           state_d = S_ISSUE;
                end
                S_FINISH: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and output next values. Pulses are computed from the
    // next state so they appear registered in the state they belong to.
    always_comb begin
        tick_d  = tick_q;
        steps_d = steps_q;
        tmo_d   = tmo_q;
        error_d = error_q;
        if (!abort_i) begin
            unique case (state_q)
                S_IDLE: begin
                    if (run_i) begin
                        steps_d = cfg_num_steps_i;
                        error_d = 1'b0;
                        if (cfg_num_steps_i != '0) tick_d = cfg_tick_start_i;
                    end
                end
                S_ISSUE: tmo_d = '0;
                S_WAIT_BUSY: begin
                    if (!LIF_busy_i) begin
                        if (tmo_hit) error_d = 1'b1;
                        else         tmo_d   = tmo_q + TW'(1);
                    end
                end
                S_ADVANCE: begin
                    steps_d = steps_q - INPUT_RESO'(1);
                    if (!last_step) tick_d = tick_q - INPUT_RESO'(1);
                end
                default: begin
                end
            endcase
        end
        start_d   = (state_d == S_ISSUE);
        done_d    = (state_d == S_FINISH);
        control_d = (state_d == S_ISSUE)     ||
                    (state_d == S_WAIT_BUSY) ||
                    (state_d == S_WAIT_DONE) ||
                    (state_d == S_DRAIN);
        busy_d    = (state_d != S_IDLE);
    end

    assign start_o      = start_q;
    assign tick_o       = tick_q;
    assign control_o    = control_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign steps_left_o = steps_q;

endmodule
